// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: prefetches aligned memory words into a circular byte queue and presents 2/4/6-byte instructions to decode.
module instr_fetch_queue #(
  parameter int FETCH_BYTES = 4,
  parameter int QUEUE_BYTES = 16,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_ack,
  input  logic [FETCH_BYTES*8-1:0] mem_data,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [47:0]              instr_data,
  output logic [2:0]               instr_len,
  output logic [ADDR_W-1:0]        instr_pc,
  output logic [$clog2(QUEUE_BYTES):0] queue_level
);
  localparam int PW = $clog2(QUEUE_BYTES);
  localparam int CW = PW + 1;
  localparam int FW = $clog2(FETCH_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(FETCH_BYTES - 1);
  typedef enum logic [1:0] {IDLE, REQ, REQ_DROP} state_t;
  state_t state;
  logic [7:0] q [QUEUE_BYTES];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, pushed;
  logic [ADDR_W-1:0] fetch_addr;
  logic [FW-1:0] skip;
  logic [7:0] hb [6];
  logic [2:0] len;
  logic pop, push, free;
  // head bytes beyond the valid count read as zero, so an empty queue decodes as a 2-byte slot
  always_comb begin
    for (int i = 0; i < 6; i++) hb[i] = CW'(i) < count ? q[rd_ptr + PW'(i)] : 8'h00;
  end
  assign len = hb[1][7:6] == 2'b11 ? 3'd6 : hb[1][7:6] == 2'b00 ? 3'd2 : 3'd4;
  assign instr_valid = count >= CW'(2) && count >= CW'(len);
  assign instr_len = len;
  assign queue_level = count;
  assign mem_req = state != IDLE;
  assign pop = instr_valid && instr_ready;
  assign push = state == REQ && mem_ack;
  assign pushed = CW'(FETCH_BYTES) - CW'(skip);
  assign free = {1'b0, count} + (CW+1)'(FETCH_BYTES) - (CW+1)'(skip) <= (CW+1)'(QUEUE_BYTES);
  always_comb begin
    instr_data = '0;
    for (int i = 0; i < 6; i++) instr_data[8*i +: 8] = 3'(i) < len ? hb[i] : 8'h00;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      instr_pc <= RESET_PC;
      fetch_addr <= RESET_PC & ALIGN;
      mem_addr <= RESET_PC & ALIGN;
      skip <= RESET_PC[FW-1:0];
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      instr_pc <= redirect_pc;
      fetch_addr <= redirect_pc & ALIGN;
      skip <= redirect_pc[FW-1:0];
      // a free memory port starts the new fetch at once; otherwise wait out the stale beat
      if (state == IDLE || mem_ack) begin
        state <= REQ;
        mem_addr <= redirect_pc & ALIGN;
      end else begin
        state <= REQ_DROP;
      end
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(len);
        instr_pc <= instr_pc + ADDR_W'(len);
      end
      count <= count + (push ? pushed : '0) - (pop ? CW'(len) : '0);
      if (push) begin
        for (int i = 0; i < FETCH_BYTES; i++)
          if (i >= int'(skip)) q[wr_ptr + PW'(i - int'(skip))] <= mem_data[8*i +: 8];
        wr_ptr <= wr_ptr + PW'(pushed);
        skip <= '0;
        fetch_addr <= fetch_addr + ADDR_W'(FETCH_BYTES);
      end
      if (state == IDLE && free) begin
        state <= REQ;
        mem_addr <= fetch_addr;
      end else if (state != IDLE && mem_ack) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: scoreboard plus vector table for the instruction prefetch queue.
module tb_instr_fetch_queue;
  logic clk = 0, rst = 1, redirect = 0, mem_ack = 0, instr_ready = 0;
  logic [31:0] redirect_pc = 0, mem_data = 0;
  logic mem_req, instr_valid;
  logic [31:0] mem_addr, instr_pc;
  logic [47:0] instr_data;
  logic [2:0] instr_len;
  logic [4:0] queue_level;

  instr_fetch_queue dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_len(instr_len), .instr_pc(instr_pc), .queue_level(queue_level)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] pc; logic [2:0] len; logic [47:0] data;} ins_t;
  typedef struct {logic [31:0] pc; logic [47:0] bytes; logic [2:0] len; logic [47:0] data;} vec_t;
  ins_t sb[$];
  ins_t log_q[$];
  vec_t vecs[7];
  logic [7:0] mem [1024];
  int total = 0, bad = 0, lat = 0, cnt = 0, max_level = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference decode straight from the memory image
  function automatic ins_t model(logic [31:0] pc);
    ins_t r;
    logic [15:0] h;
    h = {mem[10'(pc + 1)], mem[10'(pc)]};
    r.pc = pc;
    r.len = h[15:14] == 2'b00 ? 3'd2 : h[15:14] == 2'b11 ? 3'd6 : 3'd4;
    r.data = '0;
    for (int b = 0; b < 6; b++) if (b < int'(r.len)) r.data[8*b +: 8] = mem[10'(pc + 32'(b))];
    return r;
  endfunction

  task automatic push_stream(logic [31:0] pc, int n);
    ins_t e;
    for (int k = 0; k < n; k++) begin
      e = model(pc);
      sb.push_back(e);
      pc = pc + 32'(e.len);
    end
  endtask

  task automatic tick();
    ins_t e;
    if (!rst && !redirect && instr_valid && instr_ready) begin
      log_q.push_back('{instr_pc, instr_len, instr_data});
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (instr_pc !== e.pc || instr_len !== e.len || instr_data !== e.data) begin
          bad++;
          $display("FAIL pop: got pc=%0h len=%0d data=%0h expected pc=%0h len=%0d data=%0h",
                   instr_pc, instr_len, instr_data, e.pc, e.len, e.data);
        end
      end
    end
    @(posedge clk);
    #1;
    if (int'(queue_level) > max_level) max_level = int'(queue_level);
    if (mem_req && cnt >= lat) begin
      mem_ack = 1;
      for (int b = 0; b < 4; b++) mem_data[8*b +: 8] = mem[10'(mem_addr + 32'(b))];
      cnt = 0;
    end else begin
      mem_ack = 0;
      mem_data = 32'hdeadbeef;
      cnt = mem_req ? cnt + 1 : 0;
    end
  endtask

  task automatic redir(logic [31:0] pc, int n);
    sb.delete();
    redirect = 1;
    redirect_pc = pc;
    tick();
    redirect = 0;
    log_q.delete();
    push_stream(pc, n);
  endtask

  task automatic wait_pops(int n, int budget, string name);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(name, 64'(log_q.size() >= n), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic held, stale, early, seen4, found;
    logic [79:0] t2;
    vecs[0] = '{32'h080, 48'hffffffff1234, 3'd2, 48'h1234};
    vecs[1] = '{32'h088, 48'hddccbbaa4000, 3'd4, 48'hbbaa4000};
    vecs[2] = '{32'h090, 48'heeee03028001, 3'd4, 48'h03028001};
    vecs[3] = '{32'h098, 48'h09080706c305, 3'd6, 48'h09080706c305};
    vecs[4] = '{32'h0a2, 48'h04030201ffef, 3'd6, 48'h04030201ffef};
    vecs[5] = '{32'h0b6, 48'h555530207f10, 3'd4, 48'h30207f10};
    vecs[6] = '{32'h0c2, 48'h111111113fff, 3'd2, 48'h3fff};
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 11);
    mem[0] = 8'h34; mem[1] = 8'h12; mem[2] = 8'h01; mem[3] = 8'h00;

    // reset state and first fetch
    instr_ready = 1;
    tick(); tick();
    check("rst_mem_req", mem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_data", instr_data, 0);
    check("rst_len", instr_len, 2);
    check("rst_level", queue_level, 0);
    check("rst_pc", instr_pc, 0);
    rst = 0;
    log_q.delete();
    push_stream(0, 8);
    tick();
    check("t1_req", mem_req, 1);
    check("t1_addr", mem_addr, 0);
    wait_pops(2, 20, "t1_pops");
    if (log_q.size() >= 2) begin
      check("t1_data0", log_q[0].data, 48'h1234);
      check("t1_pc0", log_q[0].pc, 0);
      check("t1_data1", log_q[1].data, 48'h0001);
      check("t1_pc1", log_q[1].pc, 2);
      check("t1_len1", log_q[1].len, 2);
    end

    // 6-byte instruction straddling two fetch words, slow memory
    t2 = 80'h6655_4433_2211_c000_1234;
    for (int i = 0; i < 10; i++) mem[i] = t2[8*i +: 8];
    lat = 3;
    redir(0, 6);
    early = 0; seen4 = 0;
    repeat (40) begin
      if (instr_valid && instr_pc == 2 && !seen4) early = 1;
      if (mem_ack && mem_addr == 4) seen4 = 1;
      tick();
    end
    check("t2_early_valid", early, 0);
    check("t2_second_fetch", seen4, 1);
    if (log_q.size() >= 2) begin
      check("t2_pc", log_q[1].pc, 2);
      check("t2_len", log_q[1].len, 6);
      check("t2_data", log_q[1].data, 48'h44332211c000);
    end else check("t2_pops", 64'(log_q.size()), 2);

    // back-pressure: fill to capacity then resume
    instr_ready = 0;
    lat = 0;
    redir(32'h200, 0);
    max_level = 0;
    repeat (30) tick();
    check("t3_level", queue_level, 16);
    check("t3_req_off", mem_req, 0);
    check("t3_max_level", 64'(max_level), 16);
    push_stream(32'h200, 60);
    instr_ready = 1;
    k = 0;
    while (!mem_req && k < 10) begin tick(); k++; end
    check("t3_resume", mem_req, 1);
    repeat (40) tick();
    check("t3_stream", 64'(log_q.size() >= 10), 1);

    // unaligned redirect
    redir(32'h102, 20);
    check("t4_req", mem_req, 1);
    check("t4_addr", mem_addr, 32'h100);
    tick();
    check("t4_level", queue_level, 2);
    wait_pops(1, 20, "t4_pops");
    if (log_q.size() >= 1) check("t4_pc", log_q[0].pc, 32'h102);

    // redirect while a slow request is outstanding
    lat = 3;
    redir(32'h300, 0);
    k = 0;
    while (!(mem_req && mem_addr == 32'h300) && k < 10) begin tick(); k++; end
    check("t5_req", mem_req && mem_addr == 32'h300, 1);
    tick();
    redir(32'h40, 20);
    held = 1; stale = 0; k = 0;
    while (!mem_ack && k < 10) begin
      if (mem_addr != 32'h300 || !mem_req) held = 0;
      if (instr_valid) stale = 1;
      tick();
      k++;
    end
    if (mem_addr != 32'h300) held = 0;
    check("t5_ack", mem_ack, 1);
    check("t5_held", held, 1);
    tick();
    k = 0;
    while (!mem_req && k < 10) begin
      if (instr_valid) stale = 1;
      tick();
      k++;
    end
    check("t5_new_req", mem_req, 1);
    check("t5_new_addr", mem_addr, 32'h40);
    check("t5_stale", stale, 0);
    wait_pops(1, 30, "t5_pops");
    if (log_q.size() >= 1) check("t5_pc", log_q[0].pc, 32'h40);

    // length decode and zero padding vectors
    instr_ready = 0;
    lat = 0;
    for (int v = 0; v < 7; v++) begin
      for (int b = 0; b < 6; b++) mem[10'(vecs[v].pc + 32'(b))] = vecs[v].bytes[8*b +: 8];
      redir(vecs[v].pc, 0);
      k = 0;
      while (!instr_valid && k < 20) begin tick(); k++; end
      check($sformatf("vec%0d_len", v), instr_len, vecs[v].len);
      check($sformatf("vec%0d_data", v), instr_data, vecs[v].data);
      check($sformatf("vec%0d_pc", v), instr_pc, vecs[v].pc);
    end

    // redirect, mem_ack and pop in one cycle, then reset mid-request
    instr_ready = 1;
    redir(32'h200, 0);
    k = 0;
    while (!(mem_ack && instr_valid) && k < 20) begin tick(); k++; end
    found = mem_ack && instr_valid;
    check("t6_coincide", found, 1);
    redirect = 1;
    redirect_pc = 32'h2a;
    tick();
    redirect = 0;
    check("t6_level", queue_level, 0);
    check("t6_valid", instr_valid, 0);
    check("t6_pc", instr_pc, 32'h2a);
    check("t6_req", mem_req, 1);
    check("t6_addr", mem_addr, 32'h28);
    rst = 1;
    tick();
    check("t6_rst_req", mem_req, 0);
    check("t6_rst_valid", instr_valid, 0);
    check("t6_rst_data", instr_data, 0);
    check("t6_rst_len", instr_len, 2);
    check("t6_rst_level", queue_level, 0);
    check("t6_rst_pc", instr_pc, 0);
    rst = 0;
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
